// File: rtl/axi_dma_rd_engine_if.sv
// rtl/axi_dma_rd_engine_if.sv - AXI4 read address and read data channels of the DMA read engine
interface axi_dma_rd_engine_if #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_ID = 4
);
  logic                    m_arvalid;
  logic                    m_arready;
  logic [AXI_WIDTH_AD-1:0] m_araddr;
  logic [7:0]              m_arlen;
  logic [2:0]              m_arsize;
  logic [1:0]              m_arburst;
  logic [AXI_WIDTH_ID-1:0] m_arid;
  logic                    m_rvalid;
  logic                    m_rready;
  logic [AXI_WIDTH_DA-1:0] m_rdata;
  logic                    m_rlast;
  logic [1:0]              m_rresp;

  modport master (
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rlast, m_rresp
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rlast, m_rresp
  );
endinterface

// File: rtl/axi_dma_rd_engine.sv
// rtl/axi_dma_rd_engine.sv - AXI4 read-burst master: splits a block into INCR bursts and buffers beats in a FWFT FIFO
module axi_dma_rd_engine #(
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  parameter int AXI_WIDTH_ID  = 4,
  parameter int BIT_TRANS     = 18,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_DEPTH    = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_ctrl_read,
  input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
  input  logic [BIT_TRANS-1:0]    i_num_trans,
  output logic                    o_read_done,
  output logic                    o_busy,
  output logic                    o_rd_err,
  axi_dma_rd_engine_if.master     m_axi,
  output logic                    o_rd_data_vld,
  output logic [AXI_WIDTH_DA-1:0] o_rd_data,
  input  logic                    i_rd_data_rdy
);
  localparam int BPB    = AXI_WIDTH_DA / 8;
  localparam int BSHIFT = $clog2(BPB);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;
  state_t state, state_nx;

  logic [AXI_WIDTH_AD-1:0] addr;
  logic [BIT_TRANS-1:0]    remaining;
  logic [8:0]              burst_left;
  logic                    rd_err;

  logic [AXI_WIDTH_DA-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    fifo_full, fifo_empty, push, pop;

  logic [12:0] bytes_to_4k;
  logic [31:0] lim_4k, lim_rem, beats;
  logic        ar_hs, r_hs, last_beat;

  // Burst size is the tightest of: beats left, max burst, room before the next 4 KB page.
  always_comb begin
    bytes_to_4k = 13'd4096 - {1'b0, addr[11:0]};
    lim_4k      = 32'(bytes_to_4k >> BSHIFT);
    lim_rem     = 32'(remaining);
    beats       = 32'(MAX_BURST_LEN);
    if (lim_rem < beats) beats = lim_rem;
    if (lim_4k < beats)  beats = lim_4k;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign m_axi.m_arvalid = (state == S_AR);
  assign m_axi.m_araddr  = addr;
  assign m_axi.m_arlen   = (state == S_AR) ? 8'(beats - 32'd1) : 8'd0;
  assign m_axi.m_arsize  = 3'(BSHIFT);
  assign m_axi.m_arburst = 2'b01;
  assign m_axi.m_arid    = '0;
  assign m_axi.m_rready  = (state == S_R) && !fifo_full;

  assign ar_hs     = m_axi.m_arvalid && m_axi.m_arready;
  assign r_hs      = m_axi.m_rvalid && m_axi.m_rready;
  assign last_beat = (burst_left == 9'd1);
  assign push      = r_hs;
  assign pop       = o_rd_data_vld && i_rd_data_rdy;

  assign o_busy        = (state != S_IDLE);
  assign o_read_done   = (state == S_DONE);
  assign o_rd_err      = rd_err;
  assign o_rd_data_vld = !fifo_empty;
  assign o_rd_data     = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (i_ctrl_read) state_nx = (i_num_trans == '0) ? S_DONE : S_AR;
      S_AR:   if (m_axi.m_arready) state_nx = S_R;
      S_R:    if (r_hs && last_beat) state_nx = (remaining == BIT_TRANS'(1)) ? S_DONE : S_AR;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The address advances at AR acceptance; araddr is only meaningful while arvalid is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr       <= '0;
      remaining  <= '0;
      burst_left <= '0;
      rd_err     <= 1'b0;
    end else begin
      if (state == S_IDLE && i_ctrl_read) begin
        addr      <= i_read_addr;
        remaining <= i_num_trans;
        rd_err    <= 1'b0;
      end
      if (ar_hs) begin
        addr       <= addr + (AXI_WIDTH_AD'(beats) << BSHIFT);
        burst_left <= 9'(beats);
      end
      if (r_hs) begin
        remaining  <= remaining - BIT_TRANS'(1);
        burst_left <= burst_left - 9'd1;
        if (m_axi.m_rresp != 2'b00 || m_axi.m_rlast != last_beat) rd_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= m_axi.m_rdata;
  end
endmodule

// File: tb/tb_axi_dma_rd_engine.sv
// tb/tb_axi_dma_rd_engine.sv - randomized bench for axi_dma_rd_engine against a burst-splitting reference model
module tb_axi_dma_rd_engine;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_ctrl_read;
  logic [31:0] i_read_addr;
  logic [17:0] i_num_trans;
  logic        o_read_done, o_busy, o_rd_err, o_rd_data_vld;
  logic [31:0] o_rd_data;
  logic        i_rd_data_rdy;

  always #5 clk = ~clk;

  axi_dma_rd_engine_if #(.AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32), .AXI_WIDTH_ID(4)) axi ();

  axi_dma_rd_engine #(
    .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32), .AXI_WIDTH_ID(4),
    .BIT_TRANS(18), .MAX_BURST_LEN(MAXB), .FIFO_DEPTH(32)
  ) dut (
    .clk(clk), .rstn(rstn), .i_ctrl_read(i_ctrl_read), .i_read_addr(i_read_addr),
    .i_num_trans(i_num_trans), .o_read_done(o_read_done), .o_busy(o_busy), .o_rd_err(o_rd_err),
    .m_axi(axi), .o_rd_data_vld(o_rd_data_vld), .o_rd_data(o_rd_data), .i_rd_data_rdy(i_rd_data_rdy)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Written only by the initial block / tasks
  int cons_mode, err_rresp_idx, err_last_idx, blk_req_cyc;
  int base_got, base_ar, base_done, base_r, base_bad;
  logic [39:0] exp_ar_q[$];
  logic [31:0] exp_data_q[$];

  // Written only by the slave/monitor process
  logic [31:0] sl_addr_q[$];
  int          sl_len_q[$];
  int          sl_beat = 0;
  bit          r_hold = 0, arv_prev = 0;
  int          done_cnt = 0, done_cyc = 0, r_hs_cnt = 0, last_r_cyc = 0, prev_end = -1;
  int          arv_first_req = -2, arv_first_cyc = -1, b2b_bad = 0, ar_overlap = 0;
  logic [39:0] got_ar_q[$];
  logic [31:0] got_q[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference: split into bursts from the block's rules, independent of any engine state.
  function automatic void model(input logic [31:0] a0, input int n);
    logic [31:0] a = a0;
    int rem = n, b, room;
    exp_ar_q.delete();
    exp_data_q.delete();
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_ar_q.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) exp_data_q.push_back(mem_f(a + 32'(4 * i)));
      a = a + 32'(4 * b);
      rem = rem - b;
    end
  endfunction

  // AXI slave with random AR/R timing, plus done/handshake monitors
  always @(negedge clk) begin
    if (!rstn) begin
      axi.m_arready = 1'b0;
      axi.m_rvalid  = 1'b0;
      axi.m_rdata   = '0;
      axi.m_rlast   = 1'b0;
      axi.m_rresp   = 2'b00;
      sl_addr_q.delete();
      sl_len_q.delete();
      sl_beat  = 0;
      r_hold   = 0;
      arv_prev = 0;
    end else begin
      if (o_read_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (axi.m_arvalid && !arv_prev) begin
        if (arv_first_req != blk_req_cyc) begin
          arv_first_req = blk_req_cyc;
          arv_first_cyc = cyc;
        end
        if (prev_end >= blk_req_cyc && cyc != prev_end + 1) b2b_bad++;
      end
      arv_prev = axi.m_arvalid;
      axi.m_arready = ($urandom_range(0, 3) != 0);
      if (!r_hold) begin
        axi.m_rvalid = 1'b0;
        axi.m_rlast  = 1'b0;
        axi.m_rresp  = 2'b00;
        if (sl_len_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          axi.m_rvalid = 1'b1;
          r_hold = 1;
          axi.m_rdata = mem_f(sl_addr_q[0] + 32'(4 * sl_beat));
          axi.m_rlast = (sl_beat == sl_len_q[0]) || (r_hs_cnt == err_last_idx);
          axi.m_rresp = (r_hs_cnt == err_rresp_idx) ? 2'b10 : 2'b00;
        end
      end
      if (axi.m_arvalid && axi.m_arready) begin
        if (sl_len_q.size() != 0) ar_overlap++;
        sl_addr_q.push_back(axi.m_araddr);
        sl_len_q.push_back(int'(axi.m_arlen));
        got_ar_q.push_back({axi.m_araddr, axi.m_arlen});
      end
      if (axi.m_rvalid && axi.m_rready) begin
        r_hold = 0;
        r_hs_cnt++;
        last_r_cyc = cyc;
        if (sl_beat == sl_len_q[0]) begin
          void'(sl_addr_q.pop_front());
          void'(sl_len_q.pop_front());
          sl_beat  = 0;
          prev_end = cyc;
        end else begin
          sl_beat++;
        end
      end
    end
  end

  // Downstream consumer: pop is committed when vld & rdy are seen before the edge
  always @(negedge clk) begin
    if (!rstn) begin
      i_rd_data_rdy = 1'b0;
    end else begin
      i_rd_data_rdy = (cons_mode == 1) || (cons_mode == 2 && $urandom_range(0, 2) != 0);
      if (o_rd_data_vld && i_rd_data_rdy) got_q.push_back(o_rd_data);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_block(input logic [31:0] a, input int n);
    model(a, n);
    base_got  = got_q.size();
    base_ar   = got_ar_q.size();
    base_done = done_cnt;
    base_r    = r_hs_cnt;
    base_bad  = b2b_bad + ar_overlap;
    i_read_addr = a;
    i_num_trans = 18'(n);
    i_ctrl_read = 1'b1;
    blk_req_cyc = cyc;
    step(1);
    i_ctrl_read = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == base_done && k < 3000) begin
      step(1);
      k++;
    end
    n_checks++;
    if (done_cnt == base_done) $display("FAIL %s done_timeout: no o_read_done after %0d cycles", tag, k);
    else n_pass++;
    k = 0;
    while (got_q.size() - base_got < exp_data_q.size() && k < 3000) begin
      step(1);
      k++;
    end
    step(3);
  endtask

  task automatic test_reset();
    step(2);
    n_checks++;
    if ({o_read_done, o_busy, o_rd_err, axi.m_arvalid, axi.m_rready, o_rd_data_vld} !== 6'b0 ||
        axi.m_araddr !== 32'h0 || axi.m_arlen !== 8'h0 || o_rd_data !== 32'h0 || axi.m_arid !== 4'h0)
      $display("FAIL reset_outputs: done=%b busy=%b err=%b arvalid=%b rready=%b vld=%b araddr=%h arlen=%h data=%h, required all 0",
               o_read_done, o_busy, o_rd_err, axi.m_arvalid, axi.m_rready, o_rd_data_vld, axi.m_araddr, axi.m_arlen, o_rd_data);
    else n_pass++;
    n_checks++;
    if (axi.m_arsize !== 3'd2 || axi.m_arburst !== 2'b01)
      $display("FAIL reset_consts: arsize=%0d arburst=%b, required 2 and 01", axi.m_arsize, axi.m_arburst);
    else n_pass++;
    rstn = 1'b1;
    step(2);
    n_checks++;
    if (o_busy !== 1'b0 || axi.m_arvalid !== 1'b0)
      $display("FAIL reset_release: busy=%b arvalid=%b, required 0 0", o_busy, axi.m_arvalid);
    else n_pass++;
  endtask

  task automatic test_bursts();
    logic [31:0] a;
    int n, bad;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      begin a = 32'h1000_0000; n = 16; end
      else if (i == 1) begin a = 32'h2000_0000; n = 40; end
      else if (i == 2) begin a = 32'h0000_0FF0; n = 16; end
      else begin
        a = ($urandom & 32'hFFFF_F000) | 32'(3840 + 4 * $urandom_range(0, 63));
        n = $urandom_range(1, 70);
      end
      cons_mode = (i < 3) ? 1 : 2;
      start_block(a, n);
      wait_done("burst");
      bad = (got_ar_q.size() - base_ar != exp_ar_q.size()) ? 1 : 0;
      foreach (exp_ar_q[j]) if (bad == 0 && got_ar_q[base_ar + j] !== exp_ar_q[j]) bad = 1;
      n_checks++;
      if (bad != 0) $display("FAIL burst%0d ar_list: got %0d ARs, required %0d (addr %h n %0d, first required %h)",
                             i, got_ar_q.size() - base_ar, exp_ar_q.size(), a, n, exp_ar_q[0]);
      else n_pass++;
      bad = (got_q.size() - base_got != exp_data_q.size()) ? 1 : 0;
      foreach (exp_data_q[j]) if (bad == 0 && got_q[base_got + j] !== exp_data_q[j]) bad = 1;
      n_checks++;
      if (bad != 0) $display("FAIL burst%0d data: got %0d beats, required %0d beats in order", i, got_q.size() - base_got, exp_data_q.size());
      else n_pass++;
      n_checks++;
      if (done_cnt - base_done != 1) $display("FAIL burst%0d done_count: got %0d, required 1", i, done_cnt - base_done);
      else n_pass++;
      n_checks++;
      if (done_cyc != last_r_cyc + 1) $display("FAIL burst%0d done_timing: done at %0d, required %0d", i, done_cyc, last_r_cyc + 1);
      else n_pass++;
      n_checks++;
      if (arv_first_cyc != blk_req_cyc + 1) $display("FAIL burst%0d ar_latency: arvalid at %0d, required %0d", i, arv_first_cyc, blk_req_cyc + 1);
      else n_pass++;
      n_checks++;
      if (b2b_bad + ar_overlap != base_bad) $display("FAIL burst%0d burst_spacing: %0d violations, required 0", i, b2b_bad + ar_overlap - base_bad);
      else n_pass++;
      n_checks++;
      if (o_rd_err !== 1'b0 || o_busy !== 1'b0) $display("FAIL burst%0d idle_clean: err=%b busy=%b, required 0 0", i, o_rd_err, o_busy);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    cons_mode = 0;
    start_block(32'h3000_0000, 40);
    step(300);
    n_checks++;
    if (r_hs_cnt - base_r != 32 || axi.m_rready !== 1'b0 || o_rd_data_vld !== 1'b1 || done_cnt != base_done)
      $display("FAIL bp_stall: beats=%0d rready=%b vld=%b done=%0d, required 32 0 1 0",
               r_hs_cnt - base_r, axi.m_rready, o_rd_data_vld, done_cnt - base_done);
    else n_pass++;
    cons_mode = 1;
    wait_done("bp");
    bad = (got_q.size() - base_got != exp_data_q.size()) ? 1 : 0;
    foreach (exp_data_q[j]) if (bad == 0 && got_q[base_got + j] !== exp_data_q[j]) bad = 1;
    n_checks++;
    if (bad != 0 || done_cnt - base_done != 1)
      $display("FAIL bp_data: got %0d beats done=%0d, required 40 beats in order and 1 done", got_q.size() - base_got, done_cnt - base_done);
    else n_pass++;
  endtask

  task automatic test_errors();
    int bad;
    cons_mode = 2;
    err_rresp_idx = r_hs_cnt + 3;
    start_block(32'h4000_0000, 16);
    wait_done("err_resp");
    err_rresp_idx = -1;
    bad = (got_q.size() - base_got != exp_data_q.size()) ? 1 : 0;
    foreach (exp_data_q[j]) if (bad == 0 && got_q[base_got + j] !== exp_data_q[j]) bad = 1;
    n_checks++;
    if (bad != 0 || done_cnt - base_done != 1 || o_rd_err !== 1'b1)
      $display("FAIL err_resp: err=%b beats=%0d done=%0d, required err 1, 16 beats, 1 done", o_rd_err, got_q.size() - base_got, done_cnt - base_done);
    else n_pass++;
    step(5);
    n_checks++;
    if (o_rd_err !== 1'b1) $display("FAIL err_sticky: err=%b, required 1", o_rd_err);
    else n_pass++;
    err_last_idx = r_hs_cnt + 5;
    start_block(32'h4000_1000, 16);
    n_checks++;
    if (o_rd_err !== 1'b0) $display("FAIL err_clear: err=%b after new request, required 0", o_rd_err);
    else n_pass++;
    wait_done("err_last");
    err_last_idx = -1;
    bad = (got_q.size() - base_got != exp_data_q.size()) ? 1 : 0;
    foreach (exp_data_q[j]) if (bad == 0 && got_q[base_got + j] !== exp_data_q[j]) bad = 1;
    n_checks++;
    if (bad != 0 || done_cnt - base_done != 1 || o_rd_err !== 1'b1 || got_ar_q.size() - base_ar != 1)
      $display("FAIL err_early_last: err=%b beats=%0d done=%0d ars=%0d, required err 1, 16 beats, 1 done, 1 AR",
               o_rd_err, got_q.size() - base_got, done_cnt - base_done, got_ar_q.size() - base_ar);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int bad;
    cons_mode = 1;
    start_block(32'h5000_0000, 40);
    for (int p = 0; p < 2; p++) begin
      step(p == 0 ? 3 : 20);
      i_read_addr = 32'h6000_0000;
      i_num_trans = 18'd5;
      i_ctrl_read = 1'b1;
      step(1);
      i_ctrl_read = 1'b0;
    end
    wait_done("busy");
    step(10);
    bad = (got_ar_q.size() - base_ar != exp_ar_q.size()) ? 1 : 0;
    foreach (exp_ar_q[j]) if (bad == 0 && got_ar_q[base_ar + j] !== exp_ar_q[j]) bad = 1;
    n_checks++;
    if (bad != 0) $display("FAIL busy_ar_list: got %0d ARs, required %0d of first block only", got_ar_q.size() - base_ar, exp_ar_q.size());
    else n_pass++;
    n_checks++;
    if (done_cnt - base_done != 1 || o_busy !== 1'b0 || got_q.size() - base_got != 40)
      $display("FAIL busy_ignore: done=%0d busy=%b beats=%0d, required 1 0 40", done_cnt - base_done, o_busy, got_q.size() - base_got);
    else n_pass++;
  endtask

  task automatic test_zero();
    int k = 0;
    start_block(32'h7000_0000, 0);
    while (done_cnt == base_done && k < 10) begin
      step(1);
      k++;
    end
    step(4);
    n_checks++;
    if (done_cnt - base_done != 1 || done_cyc - blk_req_cyc < 1 || done_cyc - blk_req_cyc > 2)
      $display("FAIL zero_done: done=%0d after %0d cycles, required 1 pulse within 2 cycles", done_cnt - base_done, done_cyc - blk_req_cyc);
    else n_pass++;
    n_checks++;
    if (got_ar_q.size() != base_ar || r_hs_cnt != base_r || o_busy !== 1'b0)
      $display("FAIL zero_no_traffic: ars=%0d beats=%0d busy=%b, required 0 0 0", got_ar_q.size() - base_ar, r_hs_cnt - base_r, o_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k = 0, bad;
    cons_mode = 0;
    start_block(32'h8000_0000, 40);
    while (r_hs_cnt - base_r < 10 && k < 200) begin
      step(1);
      k++;
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({o_read_done, o_busy, o_rd_err, axi.m_arvalid, axi.m_rready, o_rd_data_vld} !== 6'b0 ||
        axi.m_araddr !== 32'h0 || axi.m_arlen !== 8'h0 || o_rd_data !== 32'h0)
      $display("FAIL midreset_outputs: busy=%b arvalid=%b rready=%b vld=%b araddr=%h data=%h, required all 0 (beats before reset %0d)",
               o_busy, axi.m_arvalid, axi.m_rready, o_rd_data_vld, axi.m_araddr, o_rd_data, r_hs_cnt - base_r);
    else n_pass++;
    step(2);
    rstn = 1'b1;
    step(2);
    n_checks++;
    if (o_rd_data_vld !== 1'b0 || o_busy !== 1'b0) $display("FAIL midreset_empty: vld=%b busy=%b, required 0 0", o_rd_data_vld, o_busy);
    else n_pass++;
    cons_mode = 2;
    start_block(32'h9000_0100, 20);
    wait_done("recover");
    bad = (got_q.size() - base_got != exp_data_q.size()) ? 1 : 0;
    foreach (exp_data_q[j]) if (bad == 0 && got_q[base_got + j] !== exp_data_q[j]) bad = 1;
    n_checks++;
    if (bad != 0 || done_cnt - base_done != 1)
      $display("FAIL midreset_recover: beats=%0d done=%0d, required 20 beats in order and 1 done", got_q.size() - base_got, done_cnt - base_done);
    else n_pass++;
  endtask

  initial begin
    i_ctrl_read   = 1'b0;
    i_read_addr   = '0;
    i_num_trans   = '0;
    cons_mode     = 1;
    err_rresp_idx = -1;
    err_last_idx  = -1;
    blk_req_cyc   = -1;
    test_reset();
    test_bursts();
    test_backpressure();
    test_errors();
    test_busy_ignore();
    test_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
